// File: rtl/clockdiv_multi_if.sv
// Divisor write port: valid/ready handshake carrying a channel index and a new divisor.
// The master drives the request; the divider (slave) answers with ready.
interface clockdiv_multi_if #(
  parameter int CW  = 26,
  parameter int CHW = 2
);
  logic           wr_valid;
  logic [CHW-1:0] wr_ch;
  logic [CW-1:0]  wr_div;
  logic           wr_ready;

  modport master (output wr_valid, output wr_ch, output wr_div, input wr_ready);
  modport slave  (input wr_valid, input wr_ch, input wr_div, output wr_ready);
endinterface

// File: rtl/clockdiv_multi.sv
// Multi-channel clock-enable generator: per channel a tick pulse every D enabled cycles
// and a toggling square wave, with run-time divisor updates applied only at a wrap.
module clockdiv_multi #(
  parameter int                NCH         = 3,
  parameter int                CW          = 26,
  parameter logic [NCH*CW-1:0] DEFAULT_DIV = {26'd2, 26'd100_000, 26'd1_000_000},
  parameter int                CHW         = 2
) (
  input  logic            clk,
  input  logic            clr,
  input  logic [NCH-1:0]  en_i,
  input  logic            sync_i,
  clockdiv_multi_if.slave wr,
  output logic [NCH-1:0]  tick_o,
  output logic [NCH-1:0]  sq_o
);

  logic [NCH-1:0][CW-1:0] cnt_q, cnt_d;
  logic [NCH-1:0][CW-1:0] div_act_q, div_act_d;
  logic [NCH-1:0][CW-1:0] div_pend_q, div_pend_d;
  logic [NCH-1:0][CW-1:0] tc;
  logic [NCH-1:0]         pend_q, pend_d;
  logic [NCH-1:0]         tick_q, tick_d;
  logic [NCH-1:0]         sq_q, sq_d;
  logic                   pend_sel;
  logic                   accept;

  // Out-of-range channel indices see no pending write, so they are always accepted.
  always_comb begin
    pend_sel = 1'b0;
    for (int i = 0; i < NCH; i++) begin
      if (wr.wr_ch == CHW'(i)) pend_sel = pend_q[i];
    end
  end

  assign wr.wr_ready = ~pend_sel & ~sync_i & ~clr;
  assign accept      = wr.wr_valid & wr.wr_ready;

  // Terminal count D-1, where a divisor of 0 behaves as 1.
  always_comb begin
    for (int i = 0; i < NCH; i++) begin
      tc[i] = (div_act_q[i] == '0) ? '0 : div_act_q[i] - CW'(1);
    end
  end

  always_comb begin
    cnt_d      = cnt_q;
    div_act_d  = div_act_q;
    div_pend_d = div_pend_q;
    pend_d     = pend_q;
    tick_d     = '0;
    sq_d       = sq_q;
    for (int i = 0; i < NCH; i++) begin
      if (sync_i) begin
        cnt_d[i] = '0;
        sq_d[i]  = 1'b0;
        if (pend_q[i]) begin
          div_act_d[i] = div_pend_q[i];
          pend_d[i]    = 1'b0;
        end
      end else begin
        if (en_i[i]) begin
          if (cnt_q[i] == tc[i]) begin
            cnt_d[i]  = '0;
            tick_d[i] = 1'b1;
            sq_d[i]   = ~sq_q[i];
            if (pend_q[i]) begin
              div_act_d[i] = div_pend_q[i];
              pend_d[i]    = 1'b0;
            end
          end else begin
            cnt_d[i] = cnt_q[i] + CW'(1);
          end
        end else if (pend_q[i]) begin
          // Idle channel: take the new divisor right away and restart the period.
          div_act_d[i] = div_pend_q[i];
          pend_d[i]    = 1'b0;
          cnt_d[i]     = '0;
        end
        // ready is low while pend is set, so this never collides with the apply above.
        if (accept && (wr.wr_ch == CHW'(i))) begin
          div_pend_d[i] = wr.wr_div;
          pend_d[i]     = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      cnt_q      <= '0;
      div_act_q  <= DEFAULT_DIV;
      div_pend_q <= '0;
      pend_q     <= '0;
      tick_q     <= '0;
      sq_q       <= '0;
    end else begin
      cnt_q      <= cnt_d;
      div_act_q  <= div_act_d;
      div_pend_q <= div_pend_d;
      pend_q     <= pend_d;
      tick_q     <= tick_d;
      sq_q       <= sq_d;
    end
  end

  assign tick_o = tick_q;
  assign sq_o   = sq_q;

endmodule

// File: doc/clockdiv_multi.md
Name: clockdiv_multi

Overview:
Parametrised successor to the fixed clock divider. It generates NCH independent clock-enable ticks and toggle-style divided square waves from the master clock. Each channel has a divisor that is reprogrammable at run time through a valid/ready write port, with glitch-free update at the channel wrap. It feeds 7-seg scan, game-tick timers and blink logic, which use `tick` as a clock enable, not as a clock.

Parameters:
- NCH, 3, number of channels (1..16)
- CW, 26, divisor and counter width in bits
- DEFAULT_DIV, {26'd2, 26'd100_000, 26'd1_000_000}, packed NCH*CW vector; channel i reset divisor at [i*CW +: CW]
- CHW, 2, width of wr_ch; must be >= max(1, clog2(NCH))

Ports:
- clk  in  1  master clock (50 MHz)
- clr  in  1  synchronous active-high reset
- en  in  NCH  per-channel count enable
- sync  in  1  synchronous restart of all channels, keeps divisors
- wr_valid  in  1  divisor write request
- wr_ch  in  CHW  target channel
- wr_div  in  CW  new divisor
- wr_ready  out  1  write accepted when wr_valid && wr_ready
- tick  out  NCH  one-cycle pulse per channel period, registered
- sq  out  NCH  square wave, toggles on each tick, registered

Behaviour:
- Per channel state: cnt[CW], div_act[CW], pend (1 bit), div_pend[CW], tick reg, sq reg.
- Effective divisor D = max(div_act, 1). A written value of 0 behaves as 1.
- Priority each edge: clr > sync > normal operation.
- clr=1: cnt=0, div_act=DEFAULT_DIV slice, pend=0, tick=0, sq=0 for all channels. A pending write is discarded. clr mid-operation behaves identically.
- sync=1 (no clr): cnt=0, tick=0, sq=0 for all channels. If pend, div_act<=div_pend and pend<=0. No write is accepted that cycle (wr_ready=0).
- Normal, en[i]=1:
  - If cnt==D-1: cnt<=0, tick<=1, sq<=~sq. If pend, div_act<=div_pend and pend<=0.
  - Else: cnt<=cnt+1, tick<=0.
- Normal, en[i]=0: cnt and sq hold, tick<=0. If pend, it is applied at the next edge (div_act<=div_pend, pend<=0, cnt<=0).
- Timing after clr release: the first tick is high during cycle D, counting the first enabled edge as 1. Subsequent ticks follow every D enabled cycles. D=1 gives tick high on every enabled cycle. sq period is 2*D enabled cycles at 50% duty.
- Write port:
  - wr_ready = ~pend[wr_ch] && ~sync && ~clr, combinational from registers and inputs.
  - On accept: div_pend[wr_ch]<=wr_div and pend<=1. The change is visible at the next edge.
  - wr_ch >= NCH: always ready, accepted and dropped with no state change.
- Simultaneous events:
  - Accept in the same cycle the channel wraps: that wrap uses the old div_act; the new value applies at the following wrap.
  - Accept while the channel is in the wrap cycle of an earlier pending write is impossible, because wr_ready=0 while pend=1.
  - sync together with wr_valid: no accept; the master must hold valid.
- cnt never exceeds D-1, because divisor changes only take effect at a wrap or while disabled. No wrap-around overflow at CW bits.
- Latency: write accept to new period start <= D_old cycles when enabled; 1 cycle when disabled.

Test Plan (NCH=3, CW=8, CHW=2, DEFAULT_DIV={8'd1, 8'd5, 8'd2}, i.e. ch0=2, ch1=5, ch2=1):
- clr for 2 cycles, then en=3'b111 for 20 cycles -> tick0 high on cycles 2,4,6..; tick1 on 5,10,15,20; tick2 every cycle; sq0 period 4; sq1 toggles at 5,10.
- Cycle 7: write ch1 div=3 -> accepted with wr_ready=1; wr_ready for ch1 goes 0 until the wrap at cycle 10; tick1 at 10, then 13, 16, 19.
- Hold a second write to ch1 (div=4) asserted from cycle 8 -> wr_ready=0 through cycle 10; accepted on cycle 11; tick1 at 13, then 17, 21.
- Drop en[0] for cycles 5-7 mid-count -> cnt0 frozen, tick0=0, sq0 held; next tick0 lands 3 cycles late; period resumes at 2.
- Assert sync on cycle 12 with a ch0 write (div=4) pending -> all cnt=0, sq=0, tick=0, div_act0=4; ticks at 4 (ch0), 5 (ch1), 1 (ch2) cycles after release.
- Write ch2 div=0, then wr_ch=3 div=9 -> ch2 keeps ticking every cycle; the wr_ch=3 write is accepted and leaves no state change. Then clr with pend set -> defaults restored and pend cleared.
